// File: rtl/control_rd_seq.sv
// Read-sequence controller: walks rd_stage 1 -> (2..11 per pass) -> 12 -> 0, with
// stall freezing progress and a latched pass count captured at start acceptance.
module control_rd_seq #(
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic [PASS_W-1:0] num_passes,
    output logic [3:0]        rd_stage,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_SETUP      = 4'd1;
    localparam logic [3:0] ST_LOOP_FIRST = 4'd2;
    localparam logic [3:0] ST_LOOP_LAST  = 4'd11;
    localparam logic [3:0] ST_DONE       = 4'd12;

    localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);

    logic [3:0]        stage_q, stage_d;
    logic [PASS_W-1:0] pass_q,  pass_d;
    logic [PASS_W-1:0] count_q, count_d;

    always_comb begin
        stage_d = stage_q;
        pass_d  = pass_q;
        count_d = count_q;
        if (stage_q == ST_IDLE) begin
            if (start) begin
                stage_d = ST_SETUP;
                pass_d  = '0;
                // A zero request still runs one pass.
                count_d = (num_passes == '0) ? PASS_ONE : num_passes;
            end
        end else if (stage_q < ST_LOOP_LAST) begin
            if (!stall) begin
                stage_d = stage_q + 4'd1;
            end
        end else if (stage_q == ST_LOOP_LAST) begin
            if (!stall) begin
                if (pass_q == count_q - PASS_ONE) begin
                    stage_d = ST_DONE;
                end else begin
                    stage_d = ST_LOOP_FIRST;
                    pass_d  = pass_q + PASS_ONE;
                end
            end
        end else if (stage_q == ST_DONE) begin
            stage_d = ST_IDLE;
        end else begin
            // Stages 13..15 are unreachable; recover silently without a done pulse.
            stage_d = ST_IDLE;
            pass_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= ST_IDLE;
            pass_q  <= '0;
            count_q <= PASS_ONE;
        end else begin
            stage_q <= stage_d;
            pass_q  <= pass_d;
            count_q <= count_d;
        end
    end

    assign rd_stage = stage_q;
    assign pass_idx = pass_q;
    assign busy     = (stage_q != ST_IDLE);
    assign done     = (stage_q == ST_DONE);

endmodule

// File: tb/tb_control_rd_seq.sv
// Bench for control_rd_seq: each sequence is expanded into a per-cycle expected trace
// plus the inputs to drive in that cycle; both queues are consumed one entry per cycle.
module tb_control_rd_seq;

    localparam int PASS_W = 8;
    localparam int EW     = 15;  // {chk_pass, done, busy, stage[3:0], pass[7:0]}
    localparam int DW     = 11;  // {rst, start, stall, num_passes[7:0]}

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stall;
    logic [PASS_W-1:0] num_passes;
    logic [3:0]        rd_stage;
    logic [PASS_W-1:0] pass_idx;
    logic              busy;
    logic              done;

    control_rd_seq #(.PASS_W(PASS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stall      (stall),
        .num_passes (num_passes),
        .rd_stage   (rd_stage),
        .pass_idx   (pass_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] drv_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cycle(input bit chk, input int stg, input int pidx,
                              input bit r, input bit st, input bit sl, input int np);
        exp_q.push_back({chk, stg == 12, stg != 0, 4'(stg), 8'(pidx)});
        drv_q.push_back({r, st, sl, 8'(np)});
    endtask

    // Expected trace of one sequence, starting with the idle cycle in which start is driven.
    task automatic build_seq(input int passes, input int stall_stage, input int stall_pass,
                             input int stall_len, input bit start_at_12, input bit stall_at_12,
                             input int repulse_stage, input int repulse_np);
        int eff;
        int first;
        eff = (passes == 0) ? 1 : passes;
        push_cycle(1'b0, 0, 0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), passes);
        for (int p = 0; p < eff; p++) begin
            first = (p == 0) ? 1 : 2;
            for (int s = first; s <= 11; s++) begin
                if (s == stall_stage && p == stall_pass) begin
                    for (int k = 0; k < stall_len; k++)
                        push_cycle(1'b1, s, p, 1'b0, 1'b0, 1'b1, $urandom_range(0, 255));
                end
                if (s == repulse_stage && p == 0)
                    push_cycle(1'b1, s, p, 1'b0, 1'b1, 1'b0, repulse_np);
                else
                    push_cycle(1'b1, s, p, 1'b0, 1'b0, 1'b0, $urandom_range(0, 255));
            end
        end
        push_cycle(1'b1, 12, eff - 1, 1'b0, start_at_12, stall_at_12, $urandom_range(0, 255));
        push_cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic run_trace();
        logic [EW-1:0] e;
        logic [DW-1:0] d;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            @(negedge clk);
            check_eq("rd_stage", 32'(rd_stage), 32'(e[11:8]));
            check_eq("busy", 32'(busy), 32'(e[12]));
            check_eq("done", 32'(done), 32'(e[13]));
            if (e[14]) check_eq("pass_idx", 32'(pass_idx), 32'(e[7:0]));
            if (done) done_seen++;
            {rst, start, stall, num_passes} = d;
        end
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic run_seq(input string tag, input int exp_done);
        done_seen = 0;
        run_trace();
        check_eq(tag, done_seen, exp_done);
    endtask

    initial begin
        int idx;
        logic [DW-1:0] tmp;

        rst        = 1'b1;
        start      = 1'b1;
        stall      = 1'b1;
        num_passes = 8'd5;
        repeat (3) @(posedge clk);
        // Reset state, with start held high throughout reset.
        push_cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        push_cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_seq("reset_no_done", 0);

        build_seq(1, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        run_seq("one_pass_done", 1);

        build_seq(3, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        run_seq("three_pass_done", 1);

        build_seq(1, 7, 0, 4, 1'b0, 1'b0, 0, 0);
        run_seq("stall7_done", 1);

        build_seq(2, 0, 0, 0, 1'b0, 1'b0, 5, 9);
        run_seq("repulse_done", 1);

        build_seq(0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
        run_seq("zero_pass_done", 1);

        build_seq(1, 0, 0, 0, 1'b1, 1'b0, 0, 0);
        push_cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_seq("start_at_12_done", 1);

        // Abort with reset at stage 9 of the third pass (start also high, must be ignored).
        build_seq(3, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        idx = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][14] && exp_q[i][11:8] == 4'd9 && exp_q[i][7:0] == 8'd2) begin
                idx = i;
                break;
            end
        end
        while (exp_q.size() > idx + 1) begin
            void'(exp_q.pop_back());
            void'(drv_q.pop_back());
        end
        tmp = drv_q[idx];
        tmp[10] = 1'b1;
        tmp[9]  = 1'b1;
        drv_q[idx] = tmp;
        push_cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        push_cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        run_seq("reset_abort_done", 0);

        build_seq(2, 11, 1, 2, 1'b0, 1'b0, 0, 0);
        run_seq("after_abort_done", 1);

        build_seq(255, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        run_seq("max_pass_done", 1);

        for (int t = 0; t < 4; t++) begin
            int np_r;
            np_r = $urandom_range(1, 6);
            build_seq(np_r, $urandom_range(1, 11), $urandom_range(0, np_r - 1),
                      $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)), 0, 0);
            run_seq("random_done", 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
